tx_packet_scheduler: RTL
========================

TX_PACKET_SCHEDULER -- requirements
Module: tx_packet_scheduler

Parameters
REQ-001 The block SHALL have parameter START_TIMEOUT, default 8: the maximum number of cycles to wait for tx_transfer_active after a packet is issued.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 16: the minimum number of idle cycles between the end of one packet and the next issue.

Interface
REQ-003 clk  in  1  the single clock; all logic is on the rising edge.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 hs_req  in  1  handshake request level; held until hs_grant.
REQ-006 hs_type  in  2  handshake type: 00 ACK, 01 NAK, 10 STALL, 11 reserved.
REQ-007 data_req  in  1  data packet request level; held until data_grant.
REQ-008 data_pid  in  1  data PID select: 0 DATA0, 1 DATA1.
REQ-009 data_len  in  7  payload bytes required in the buffer (0..64).
REQ-010 buffer_occupancy  in  7  current TX FIFO byte count.
REQ-011 tx_transfer_active  in  1  busy indication from the TX datapath.
REQ-012 tx_error  in  1  error indication from the TX datapath.
REQ-013 tx_packet  out  4  packet command to the TX datapath: 0 idle, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL.
REQ-014 hs_grant  out  1  one-cycle pulse acknowledging hs_req.
REQ-015 data_grant  out  1  one-cycle pulse acknowledging data_req.
REQ-016 pkt_done  out  1  one-cycle pulse on successful packet completion.
REQ-017 pkt_fail  out  1  one-cycle pulse on a failed or dropped packet.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have the states IDLE, ISSUE, WAIT_START, ACTIVE and GAP; all outputs SHALL be registered.
REQ-020 In IDLE, the block SHALL treat a handshake as eligible when hs_req=1.
REQ-021 In IDLE, the block SHALL treat data as eligible when data_req=1 and buffer_occupancy >= data_len (unsigned 7-bit compare).
REQ-022 Handshakes SHALL have strict priority over data.
REQ-023 When a request is selected, the next cycle SHALL be ISSUE, with tx_packet equal to the request's code for exactly that one cycle and the matching grant pulsing in the same cycle.
REQ-024 Outside ISSUE, tx_packet SHALL be 0.
REQ-025 A reserved hs_type SHALL be granted and dropped: hs_grant=1 and pkt_fail=1 in the same cycle, tx_packet stays 0, and the FSM goes to GAP.
REQ-026 From ISSUE, the FSM SHALL go to WAIT_START with its cycle counter at 1.
REQ-027 WAIT_START SHALL go to ACTIVE on tx_transfer_active=1.
REQ-028 WAIT_START SHALL pulse pkt_fail and go to GAP once the counter reaches START_TIMEOUT while tx_transfer_active is still 0.
REQ-029 ACTIVE SHALL latch a sticky error flag on any cycle with tx_error=1; the flag SHALL be cleared on entry to ISSUE.
REQ-030 On the first cycle of ACTIVE with tx_transfer_active=0, the block SHALL pulse pkt_fail if the error flag is set, otherwise pkt_done, and go to GAP.
REQ-031 GAP SHALL last exactly GAP_CYCLES cycles and then return to IDLE; requests arriving during GAP SHALL be held off, not dropped.
REQ-032 If tx_transfer_active and tx_error are both 1 in WAIT_START, the FSM SHALL enter ACTIVE with the error flag set.
REQ-033 If data is eligible but the buffer is short, the block SHALL wait in IDLE with no grant and no timeout; if hs_req arrives meanwhile, the handshake SHALL be served first.
REQ-034 If data_len > 64, the request SHALL be granted and dropped with pkt_fail, as in REQ-025.
REQ-035 Counters SHALL be wide enough for their parameter values and SHALL saturate, never wrap.
REQ-036 Exactly one of pkt_done and pkt_fail SHALL pulse per grant.

Reset
REQ-037 While rst=1 at a clock edge, the state SHALL go to IDLE.
REQ-038 On reset, tx_packet SHALL be 0, and hs_grant, data_grant, pkt_done, pkt_fail and busy SHALL be 0.
REQ-039 On reset, the counters and the error flag SHALL be cleared.
REQ-040 Reset asserted mid-packet SHALL abandon the packet with no done or fail pulse.
REQ-041 In the first cycle after reset, the block SHALL be able to accept a request.

Verification
REQ-042 ACK: hs_req=1, hs_type=00; active 2 cycles after issue, held 20 cycles -> tx_packet=3 for 1 cycle, hs_grant in the same cycle, pkt_done 1 cycle after the active fall, busy low 16 cycles later.
REQ-043 Priority: hs_req (NAK) and data_req (DATA1, eligible) in the same cycle -> tx_packet=4 first; then after completion and the gap, tx_packet=2 with data_grant.
REQ-044 Buffer gating: data_len=10 with buffer_occupancy ramping 0..12 -> no grant until occupancy is 10; the grant follows the next cycle.
REQ-045 Timeout: issue with tx_transfer_active never asserted -> pkt_fail exactly 8 cycles after WAIT_START entry, then GAP of 16 cycles.
REQ-046 tx_error pulse mid-ACTIVE -> pkt_fail, not pkt_done, at the active fall.
REQ-047 rst asserted in ACTIVE -> next cycle all outputs are 0, the state is IDLE, and no done or fail pulse occurs.

Source files
------------

// File: rtl/tx_packet_scheduler.sv
// tx_packet_scheduler: arbitrates handshake and data requests into TX packet commands,
// tracks start timeout, transfer errors and the inter-packet gap.
module tx_packet_scheduler #(
    parameter int START_TIMEOUT = 8,
    parameter int GAP_CYCLES    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hs_req,
    input  logic [1:0] hs_type,
    input  logic       data_req,
    input  logic       data_pid,
    input  logic [6:0] data_len,
    input  logic [6:0] buffer_occupancy,
    input  logic       tx_transfer_active,
    input  logic       tx_error,
    output logic [3:0] tx_packet,
    output logic       hs_grant,
    output logic       data_grant,
    output logic       pkt_done,
    output logic       pkt_fail,
    output logic       busy
);
    localparam int CMAX = START_TIMEOUT > GAP_CYCLES ? START_TIMEOUT : GAP_CYCLES;
    localparam int CW = $clog2(CMAX + 1) < 1 ? 1 : $clog2(CMAX + 1);
    localparam logic [CW-1:0] TO = CW'(START_TIMEOUT);
    localparam logic [CW-1:0] GP = CW'(GAP_CYCLES);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, ACTIVE, GAP} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic err;
    logic data_ok;
    logic err_now;
    // oversize payloads are granted regardless of occupancy so they can be dropped
    assign data_ok = data_req && (data_len > 7'd64 || buffer_occupancy >= data_len);
    assign err_now = err || tx_error;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            err        <= 1'b0;
            tx_packet  <= 4'd0;
            hs_grant   <= 1'b0;
            data_grant <= 1'b0;
            pkt_done   <= 1'b0;
            pkt_fail   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            tx_packet  <= 4'd0;
            hs_grant   <= 1'b0;
            data_grant <= 1'b0;
            pkt_done   <= 1'b0;
            pkt_fail   <= 1'b0;
            case (state)
                IDLE: begin
                    if (hs_req) begin
                        hs_grant <= 1'b1;
                        busy     <= 1'b1;
                        if (hs_type == 2'b11) begin
                            pkt_fail <= 1'b1;
                            state    <= GAP;
                            cnt      <= CW'(1);
                        end else begin
                            tx_packet <= 4'd3 + {2'b00, hs_type};
                            err       <= 1'b0;
                            state     <= ISSUE;
                        end
                    end else if (data_ok) begin
                        data_grant <= 1'b1;
                        busy       <= 1'b1;
                        if (data_len > 7'd64) begin
                            pkt_fail <= 1'b1;
                            state    <= GAP;
                            cnt      <= CW'(1);
                        end else begin
                            tx_packet <= data_pid ? 4'd2 : 4'd1;
                            err       <= 1'b0;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT_START;
                    cnt   <= CW'(1);
                end
                WAIT_START: begin
                    if (tx_transfer_active) begin
                        state <= ACTIVE;
                        err   <= tx_error;
                    end else if (cnt >= TO) begin
                        pkt_fail <= 1'b1;
                        state    <= GAP;
                        cnt      <= CW'(1);
                    end else
                        cnt <= cnt + CW'(cnt != '1);
                end
                ACTIVE: begin
                    if (!tx_transfer_active) begin
                        pkt_done <= !err_now;
                        pkt_fail <= err_now;
                        state    <= GAP;
                        cnt      <= CW'(1);
                    end else if (tx_error)
                        err <= 1'b1;
                end
                GAP: begin
                    if (cnt >= GP) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else
                        cnt <= cnt + CW'(cnt != '1);
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
